// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALUOp/opcode into the ALU A/B/select encoding and issues through a
// registered valid/ready port backed by a 2-entry skid buffer. Optional SUB decode: ALU_ISSUE_SUB_EN.
module alu_issue_stage #(
    parameter int unsigned ANCHO = 64,
    parameter int unsigned RD_W  = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_aluop,
    input  logic [10:0]      in_opcode,
    input  logic [ANCHO-1:0] in_a,
    input  logic [ANCHO-1:0] in_b,
    input  logic [RD_W-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ANCHO-1:0] out_a,
    output logic [ANCHO-1:0] out_b,
    output logic [1:0]       out_sel,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_err,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] SEL_AND  = 2'b00;
    localparam logic [1:0] SEL_OR   = 2'b01;
    localparam logic [1:0] SEL_ADD  = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
`ifdef ALU_ISSUE_SUB_EN
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
`endif

    typedef struct packed {
        logic [ANCHO-1:0] a;
        logic [ANCHO-1:0] b;
        logic [1:0]       sel;
        logic [RD_W-1:0]  rd;
        logic             err;
    } op_t;

    op_t              dec;
    op_t              or_q, or_d;
    op_t              sk_q, sk_d;
    logic             or_valid_q, or_valid_d;
    logic             sk_valid_q, sk_valid_d;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             drain;

    // Instruction decode into ALU operands and select
    always_comb begin
        dec     = '0;
        dec.a   = in_a;
        dec.b   = in_b;
        dec.rd  = in_rd;
        dec.sel = SEL_ZERO;
        dec.err = 1'b0;
        case (in_aluop)
            ALUOP_MEM: dec.sel = SEL_ADD;
            ALUOP_CBZ: begin
                dec.a   = '0;
                dec.sel = SEL_OR;
            end
            ALUOP_RTYPE: begin
                case (in_opcode)
                    OPC_ADD: dec.sel = SEL_ADD;
                    OPC_AND: dec.sel = SEL_AND;
                    OPC_ORR: dec.sel = SEL_OR;
`ifdef ALU_ISSUE_SUB_EN
                    // Adder has no carry-in, so negate B here to compute A - B
                    OPC_SUB: begin
                        dec.sel = SEL_ADD;
                        dec.b   = ~in_b + ANCHO'(1);
                    end
`endif
                    default: begin
                        dec.sel = SEL_ZERO;
                        dec.err = 1'b1;
                    end
                endcase
            end
            default: begin
                dec.sel = SEL_ZERO;
                dec.err = 1'b1;
            end
        endcase
    end

    // Next-state for output register, skid register and issue counter
    always_comb begin
        or_d       = or_q;
        sk_d       = sk_q;
        or_valid_d = or_valid_q;
        sk_valid_d = sk_valid_q;
        cnt_d      = cnt_q;
        accept     = in_valid & in_ready_q;
        drain      = or_valid_q & out_ready;

        if (drain) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (!or_valid_q || drain) begin
            if (sk_valid_q) begin
                or_d       = sk_q;
                or_valid_d = 1'b1;
                sk_valid_d = 1'b0;
            end else if (accept) begin
                or_d       = dec;
                or_valid_d = 1'b1;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (accept) begin
            // in_ready is low whenever SK is full, so this never overwrites a held entry
            sk_d       = dec;
            sk_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            or_q       <= '0;
            sk_q       <= '0;
            or_valid_q <= 1'b0;
            sk_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            or_q       <= or_d;
            sk_q       <= sk_d;
            or_valid_q <= or_valid_d;
            sk_valid_q <= sk_valid_d;
            in_ready_q <= !sk_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = or_valid_q;
    assign out_a      = or_q.a;
    assign out_b      = or_q.b;
    assign out_sel    = or_q.sel;
    assign out_rd     = or_q.rd;
    assign out_err    = or_q.err;
    assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: queue-based reference model checked every cycle, plus directed
// literal expectations. Honours ALU_ISSUE_SUB_EN for the SUB expectations.
module tb_alu_issue_stage;

    localparam int unsigned ANCHO = 64;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned CNT_W = 16;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_BAD = 11'b11111111111;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_aluop;
    logic [10:0]      in_opcode;
    logic [ANCHO-1:0] in_a;
    logic [ANCHO-1:0] in_b;
    logic [RD_W-1:0]  in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [ANCHO-1:0] out_a;
    logic [ANCHO-1:0] out_b;
    logic [1:0]       out_sel;
    logic [RD_W-1:0]  out_rd;
    logic             out_err;
    logic [CNT_W-1:0] issued_cnt;

    always #5 clk = ~clk;

    alu_issue_stage #(.ANCHO(ANCHO), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_sel(out_sel),
        .out_rd(out_rd), .out_err(out_err), .issued_cnt(issued_cnt)
    );

    int checks = 0;
    int passes = 0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endfunction

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    // Expected ALU operation for one instruction, straight from the decode table
    function automatic exp_t expect_op(input logic [1:0] op, input logic [10:0] opc,
                                       input logic [63:0] a, input logic [63:0] b,
                                       input logic [4:0] rd);
        exp_t e;
        e.a = a; e.b = b; e.rd = rd; e.err = 1'b0; e.sel = 2'd3;
        if (op == 2'd0) e.sel = 2'd2;
        else if (op == 2'd1) begin e.a = 64'd0; e.sel = 2'd1; end
        else if (op == 2'd2 && opc == OP_ADD) e.sel = 2'd2;
        else if (op == 2'd2 && opc == OP_AND) e.sel = 2'd0;
        else if (op == 2'd2 && opc == OP_ORR) e.sel = 2'd1;
`ifdef ALU_ISSUE_SUB_EN
        else if (op == 2'd2 && opc == OP_SUB) begin e.sel = 2'd2; e.b = 64'd0 - b; end
`endif
        else e.err = 1'b1;
        return e;
    endfunction

    // Reference: FIFO of up to two accepted-but-not-issued ops
    exp_t        q[$];
    int unsigned mcnt = 0;
    bit          model_ok = 1'b0;

    always @(negedge clk) begin
        bit acc, hs;
        if (model_ok) begin
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("issued_cnt", 64'(issued_cnt), 64'(CNT_W'(mcnt)));
            if (q.size() > 0) begin
                chk("out_a", out_a, q[0].a);
                chk("out_b", out_b, q[0].b);
                chk("out_sel", 64'(out_sel), 64'(q[0].sel));
                chk("out_rd", 64'(out_rd), 64'(q[0].rd));
                chk("out_err", 64'(out_err), 64'(q[0].err));
            end
        end
        if (rst) begin
            q.delete();
            mcnt = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            hs  = (q.size() > 0) && out_ready;
            acc = in_valid && (q.size() < 2);
            if (hs) begin
                void'(q.pop_front());
                mcnt++;
            end
            if (acc) q.push_back(expect_op(in_aluop, in_opcode, in_a, in_b, in_rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] op, input logic [10:0] opc,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        in_valid = 1'b1; in_aluop = op; in_opcode = opc; in_a = a; in_b = b; in_rd = rd;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [10:0] opcs [4];

    initial begin
        opcs[0] = OP_ADD; opcs[1] = OP_AND; opcs[2] = OP_ORR; opcs[3] = OP_BAD;
        rst = 1'b1; in_valid = 1'b0; in_aluop = 2'd0; in_opcode = 11'd0;
        in_a = '0; in_b = '0; in_rd = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst issued_cnt", 64'(issued_cnt), 64'd0);
        chk("rst out_a", out_a, 64'd0);
        chk("rst out_b", out_b, 64'd0);
        chk("rst out_sel", 64'(out_sel), 64'd0);
        chk("rst out_rd", 64'(out_rd), 64'd0);
        chk("rst out_err", 64'(out_err), 64'd0);

        // Memory address add, one-cycle latency
        out_ready = 1'b1;
        put(2'd0, 11'd0, 64'h10, 64'h8, 5'd3);
        tick();
        chk("mem out_valid", 64'(out_valid), 64'd1);
        chk("mem out_sel", 64'(out_sel), 64'd2);
        chk("mem out_a", out_a, 64'h10);
        chk("mem out_b", out_b, 64'h8);
        chk("mem out_rd", 64'(out_rd), 64'd3);

        // R-type back-to-back
        put(2'd2, OP_ADD, 64'd5, 64'd7, 5'd1);
        tick();
        chk("add sel", 64'(out_sel), 64'd2);
        put(2'd2, OP_AND, 64'd5, 64'd7, 5'd2);
        tick();
        chk("and sel", 64'(out_sel), 64'd0);
        put(2'd2, OP_ORR, 64'd5, 64'd7, 5'd4);
        tick();
        chk("orr sel", 64'(out_sel), 64'd1);
        put(2'd2, OP_BAD, 64'd5, 64'd7, 5'd5);
        tick();
        chk("bad sel", 64'(out_sel), 64'd3);
        chk("bad err", 64'(out_err), 64'd1);

        // CBZ pass-B
        put(2'd1, 11'd0, 64'hDEAD, 64'h5, 5'd7);
        tick();
        idle();
        chk("cbz a", out_a, 64'd0);
        chk("cbz b", out_b, 64'h5);
        chk("cbz sel", 64'(out_sel), 64'd1);
        tick();
        chk("res aluop3 reset hold", 64'(out_valid), 64'd0);

        // Back-pressure with three ops
        do_reset();
        out_ready = 1'b0;
        put(2'd0, 11'd0, 64'd1, 64'd1, 5'd1);
        tick();
        put(2'd0, 11'd0, 64'd2, 64'd2, 5'd2);
        tick();
        put(2'd3, 11'd0, 64'd3, 64'd3, 5'd3);
        chk("bp in_ready low", 64'(in_ready), 64'd0);
        chk("bp hold op1", out_a, 64'd1);
        tick();
        chk("bp in_ready still low", 64'(in_ready), 64'd0);
        chk("bp still op1", out_a, 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp op2 a", out_a, 64'd2);
        chk("bp in_ready back", 64'(in_ready), 64'd1);
        tick();
        idle();
        chk("bp op3 a", out_a, 64'd3);
        chk("bp op3 err", 64'(out_err), 64'd1);
        tick();
        chk("bp drained", 64'(out_valid), 64'd0);
        chk("bp issued_cnt", 64'(issued_cnt), 64'd3);

        // Reset while both entries are held
        out_ready = 1'b0;
        put(2'd0, 11'd0, 64'hA, 64'hA, 5'd10);
        tick();
        put(2'd0, 11'd0, 64'hB, 64'hB, 5'd11);
        tick();
        idle();
        chk("stall full", 64'(in_ready), 64'd0);
        do_reset();
        chk("mid rst out_valid", 64'(out_valid), 64'd0);
        chk("mid rst in_ready", 64'(in_ready), 64'd1);
        chk("mid rst issued_cnt", 64'(issued_cnt), 64'd0);
        chk("mid rst out_a", out_a, 64'd0);
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("no stale op", 64'(out_valid), 64'd0);
        chk("no stale cnt", 64'(issued_cnt), 64'd0);

        // SUB
        put(2'd2, OP_SUB, 64'd10, 64'd3, 5'd9);
        tick();
        idle();
        chk("sub a", out_a, 64'd10);
`ifdef ALU_ISSUE_SUB_EN
        chk("sub b", out_b, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("sub sel", 64'(out_sel), 64'd2);
        chk("sub err", 64'(out_err), 64'd0);
`else
        chk("sub b", out_b, 64'd3);
        chk("sub sel", 64'(out_sel), 64'd3);
        chk("sub err", 64'(out_err), 64'd1);
`endif
        tick();

        // Mixed stream with irregular back-pressure
        for (int i = 0; i < 48; i++) begin
            out_ready = ((i % 3) != 1) && ((i % 7) != 5);
            if ((i % 5) == 4) idle();
            else put(2'(i % 4), opcs[(i / 4) % 4], 64'(i * 32'h1111),
                     64'(i) << 8 | 64'h3C, 5'(i));
            tick();
        end
        idle();
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("stream drained", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX-side producer for the 64-bit ALU (AND/OR/ADD datapath, 2-bit select).
- Accepts decoded instructions with ALUOp and the 11-bit opcode plus operands.
- Translates them into the ALU's A, B and select encoding, then presents them through a registered valid/ready interface.
- A 2-entry skid buffer absorbs back-pressure from the EX stage without dropping or reordering operations.

Parameters:
- ANCHO, 64, operand/result width in bits.
- RD_W, 5, destination register index width.
- CNT_W, 16, width of the issued-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_aluop  in  2  00 = memory address add, 01 = CBZ pass-B, 10 = R-type, 11 = reserved.
- in_opcode  in  11  instruction opcode field; used only when in_aluop = 10.
- in_a  in  ANCHO  first operand (Rn).
- in_b  in  ANCHO  second operand (Rm or sign-extended immediate).
- in_rd  in  RD_W  destination register index.
- out_valid  out  1  ALU operation presented.
- out_ready  in  1  EX stage consumes this cycle.
- out_a  out  ANCHO  ALU A operand.
- out_b  out  ANCHO  ALU B operand.
- out_sel  out  2  ALU select: 00 AND, 01 OR, 10 ADD, 11 zero.
- out_rd  out  RD_W  destination index, forwarded unchanged.
- out_err  out  1  operation is unsupported; out_sel forced to 11.
- issued_cnt  out  CNT_W  count of completed output handshakes.

Behaviour:
- Reset: out_valid = 0, out_a = 0, out_b = 0, out_sel = 00, out_rd = 0, out_err = 0, issued_cnt = 0, skid empty, in_ready = 1 in the first cycle after reset.
- Reset mid-operation discards both held entries; no partial handshake completes.
- Decode (combinational, before registering):
  - aluop 00 -> sel 10, A = in_a, B = in_b.
  - aluop 01 -> sel 01, A = 0, B = in_b. This passes B through OR.
  - aluop 10, opcode 10001011000 (ADD) -> sel 10.
  - aluop 10, opcode 10001010000 (AND) -> sel 00.
  - aluop 10, opcode 10101010000 (ORR) -> sel 01.
  - Any other aluop 10 opcode -> sel 11, err = 1, operands passed unchanged.
  - aluop 11 -> sel 11, err = 1.
  - For R-type, opcode bits beyond the 11-bit match are ignored; the match is exact on all 11 bits.
- Storage: one output register (OR) plus one skid register (SK).
- in_ready = !SK_valid, registered from state; it does not depend combinationally on out_ready.
- Accept occurs when in_valid & in_ready. Output handshake occurs when out_valid & out_ready.
- Each cycle:
  - If OR is empty or drains, OR loads from SK if SK is valid, else from the accepted input.
  - An accepted input that cannot enter OR goes to SK.
  - SK becomes empty when it moves into OR.
- Latency: an accepted input appears on the outputs the next cycle when OR is free. Throughput is 1 op/cycle with out_ready held high.
- Ordering is strictly FIFO. out_* stay stable while out_valid & !out_ready.
- Simultaneous accept and drain with SK full is impossible because in_ready = 0 then.
- Simultaneous accept and drain with SK empty and OR full: OR reloads directly from the input.
- issued_cnt increments on each output handshake and wraps from 2^CNT_W−1 to 0.
- Error ops are issued and counted like any other op.

Optional Feature:
- Macro: ALU_ISSUE_SUB_EN.
- Defined: opcode 11001011000 (SUB) with aluop 10 decodes to sel 10, B = ~in_b + 1 (two's complement, ANCHO bits, carry out discarded), err = 0. This lets the carry-in-free adder compute A − B.
- Undefined: SUB behaves as any unsupported opcode (sel 11, err = 1, B unchanged).

Test Plan:
- Reset then idle: out_valid = 0, in_ready = 1, issued_cnt = 0. Apply aluop 00, A = 0x10, B = 0x8, rd = 3 with out_ready = 1 -> next cycle out_sel = 10, out_a = 0x10, out_b = 0x8, out_rd = 3, out_valid = 1.
- R-type decode: ADD, AND and ORR opcodes back-to-back -> out_sel sequence 10, 00, 01 on consecutive cycles. Opcode 11111111111 -> out_sel = 11, out_err = 1.
- CBZ: aluop 01, A = 0xDEAD, B = 0x5 -> out_a = 0, out_b = 0x5, out_sel = 01.
- Back-pressure: hold out_ready = 0 while feeding 3 ops -> first 2 accepted, in_ready = 0 on the following cycle, and out_* hold op1. Release out_ready -> ops 1 and 2 emerge in order, in_ready returns to 1, then op3 is accepted. issued_cnt ends at 3.
- Reset mid-stall: with OR and SK full, assert rst for 1 cycle -> out_valid = 0, in_ready = 1, issued_cnt = 0, and no stale op appears afterwards.
- SUB with A = 10, B = 3:
  - With ALU_ISSUE_SUB_EN defined -> out_b = 0xFFFF_FFFF_FFFF_FFFD, out_sel = 10, err = 0.
  - Without it -> out_sel = 11, err = 1, out_b = 3.
